decompressor: RTL and testbench



---
 rtl/flitzip_pkg.sv | 25 ++
 rtl/decompressor_delta_unpack.sv | 51 +++++
 rtl/decompressor.sv | 161 ++++++++++++++++
 tb/tb_decompressor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/flitzip_pkg.sv
// flitzip_pkg: constants and types shared by the flit compressor and decompressor.
//   CHUNK_SIZE / NCHUNK : chunk width and chunks per flit
//   DWC_W / HDR         : delta-width code width and compressed header width
//   MAX_LEGAL_CODE      : largest dw_code whose deltas still fit the link word
package flitzip_pkg;

  localparam int INPUT_WIDTH      = 128;
  localparam int OUTPUT_WIDTH     = 128;
  localparam int CHUNK_SIZE       = 8;
  localparam int CHUNKS_PER_CYCLE = 4;
  localparam int NCHUNK           = OUTPUT_WIDTH / CHUNK_SIZE;
  localparam int DWC_W            = $clog2(CHUNK_SIZE);
  localparam int HDR              = CHUNK_SIZE + DWC_W;
  // Widest delta for which HDR + NCHUNK*DW still fits, capped at the chunk width.
  localparam int MAX_DW           = ((INPUT_WIDTH - HDR) / NCHUNK > CHUNK_SIZE) ?
                                    CHUNK_SIZE : (INPUT_WIDTH - HDR) / NCHUNK;
  localparam int MAX_LEGAL_CODE   = MAX_DW - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/decompressor_delta_unpack.sv
// delta_unpack: combinational reconstruction of CPC chunks from the low end of
// the (already shifted) delta payload.
//   payload : remaining deltas, next delta at bit 0
//   dw      : delta width in bits (1..CHUNK_SIZE)
//   base    : base value added to every sign-extended delta
//   chunks  : CPC reconstructed chunks, chunk 0 at the LSBs
module delta_unpack
  import flitzip_pkg::*;
#(
  parameter int PAYLOAD_W = flitzip_pkg::INPUT_WIDTH - flitzip_pkg::HDR,
  parameter int CS        = flitzip_pkg::CHUNK_SIZE,
  parameter int CPC       = flitzip_pkg::CHUNKS_PER_CYCLE,
  parameter int DW_W      = flitzip_pkg::DWC_W + 1
) (
  input  logic [PAYLOAD_W-1:0] payload,
  input  logic [DW_W-1:0]      dw,
  input  logic [CS-1:0]        base,
  output logic [CPC*CS-1:0]    chunks
);

  logic [PAYLOAD_W-1:0] field_s;
  logic [CS-1:0]        raw_s;
  logic [CS-1:0]        mask_s;
  logic                 sign_s;
  logic [CS-1:0]        sext_s;

  // Extract each delta, sign-extend it to the chunk width and add the base (wrapping).
  always_comb begin
    chunks  = '0;
    field_s = '0;
    raw_s   = '0;
    mask_s  = '0;
    sign_s  = 1'b0;
    sext_s  = '0;
    for (int i = 0; i < CPC; i++) begin
      field_s = payload >> (i * int'(dw));
      raw_s   = field_s[CS-1:0];
      // Ones in the low dw bits; dw == CS shifts everything out and gives all ones.
      mask_s  = ~({CS{1'b1}} << dw);
      // Sign bit sits at the top of the mask.
      sign_s  = |(raw_s & (mask_s ^ (mask_s >> 1)));
      if (sign_s) begin
        sext_s = raw_s | ~mask_s;
      end else begin
        sext_s = raw_s & mask_s;
      end
      chunks[i*CS +: CS] = base + sext_s;
    end
  end

endmodule

// File: rtl/decompressor.sv
// decompressor: rebuilds a flit from a base-delta compressed word at the NoC
// ejection port. Raw flits bypass the decode loop; illegal delta-width codes
// produce a zero flit flagged with out_err.
//   in_valid/in_ready/in_is_comp/in_data : compressed word or raw flit input
//   out_valid/out_ready/out_data/out_err : reconstructed flit output
//   busy                                 : high whenever the FSM is not IDLE
module decompressor
  import flitzip_pkg::*;
#(
  parameter int INPUT_WIDTH      = flitzip_pkg::INPUT_WIDTH,
  parameter int OUTPUT_WIDTH     = flitzip_pkg::OUTPUT_WIDTH,
  parameter int CHUNK_SIZE       = flitzip_pkg::CHUNK_SIZE,
  parameter int CHUNKS_PER_CYCLE = flitzip_pkg::CHUNKS_PER_CYCLE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_is_comp,
  input  logic [INPUT_WIDTH-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] out_data,
  output logic                    out_err,
  output logic                    busy
);

  localparam int NCH       = OUTPUT_WIDTH / CHUNK_SIZE;
  localparam int CODE_W    = $clog2(CHUNK_SIZE);
  localparam int HDR_W     = CHUNK_SIZE + CODE_W;
  localparam int PAY_W     = INPUT_WIDTH - HDR_W;
  localparam int NSTEP     = NCH / CHUNKS_PER_CYCLE;
  localparam int CNT_W     = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int FIT_DW    = (INPUT_WIDTH - HDR_W) / NCH;
  localparam int MAX_CODE  = ((FIT_DW > CHUNK_SIZE) ? CHUNK_SIZE : FIT_DW) - 1;

  state_e                  state_q,     state_d;
  logic [CNT_W-1:0]        cnt_q,       cnt_d;
  logic [CHUNK_SIZE-1:0]   base_q,      base_d;
  logic [CODE_W:0]         dw_q,        dw_d;
  logic [PAY_W-1:0]        payload_q,   payload_d;
  logic [OUTPUT_WIDTH-1:0] out_data_q,  out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_err_q,   out_err_d;

  logic [CODE_W-1:0]                      code_s;
  logic                                   code_legal_s;
  logic [CHUNKS_PER_CYCLE*CHUNK_SIZE-1:0] chunks_s;

  assign code_s       = in_data[HDR_W-1:CHUNK_SIZE];
  assign code_legal_s = (int'(code_s) <= MAX_CODE);

  delta_unpack #(
    .PAYLOAD_W (PAY_W),
    .CS        (CHUNK_SIZE),
    .CPC       (CHUNKS_PER_CYCLE),
    .DW_W      (CODE_W + 1)
  ) u_unpack (
    .payload (payload_q),
    .dw      (dw_q),
    .base    (base_q),
    .chunks  (chunks_s)
  );

  // Next-state, datapath and output computation for the IDLE/DECODE/DONE FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    dw_d        = dw_q;
    payload_d   = payload_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!in_is_comp) begin
            out_data_d  = in_data[OUTPUT_WIDTH-1:0];
            out_err_d   = 1'b0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else if (code_legal_s) begin
            base_d     = in_data[CHUNK_SIZE-1:0];
            dw_d       = {1'b0, code_s} + {{CODE_W{1'b0}}, 1'b1};
            payload_d  = in_data[INPUT_WIDTH-1:HDR_W];
            cnt_d      = '0;
            out_data_d = '0;
            state_d    = DECODE;
          end else begin
            out_data_d  = '0;
            out_err_d   = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DECODE: begin
        for (int j = 0; j < CHUNKS_PER_CYCLE; j++) begin
          out_data_d[(int'(cnt_q) * CHUNKS_PER_CYCLE + j) * CHUNK_SIZE +: CHUNK_SIZE] =
            chunks_s[j*CHUNK_SIZE +: CHUNK_SIZE];
        end
        // Drop the deltas just consumed so the next group starts at bit 0.
        payload_d = payload_q >> (int'(dw_q) * CHUNKS_PER_CYCLE);
        cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(NSTEP - 1)) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = DECODE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        out_err_d   = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; async reset discards any in-flight flit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      dw_q        <= '0;
      payload_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      dw_q        <= dw_d;
      payload_q   <= payload_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_decompressor.sv
// tb_decompressor: directed plus randomized bench for decompressor with a
// behavioural base-delta reference model.
module tb_decompressor;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_is_comp;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_err;
  logic         busy;

  int tests;
  int fails;

  decompressor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_is_comp (in_is_comp),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: {err, flit} computed straight from the base-delta format rules.
  function automatic logic [128:0] model(input logic is_comp, input logic [127:0] d);
    int base;
    int code;
    int dw;
    int delta;
    logic [127:0] flit;
    if (!is_comp) return {1'b0, d};
    base = int'(d[7:0]);
    code = int'(d[10:8]);
    dw   = code + 1;
    if (11 + 16 * dw > 128 || dw > 8) return {1'b1, 128'h0};
    flit = 128'h0;
    for (int i = 0; i < 16; i++) begin
      delta = 0;
      for (int b = 0; b < dw; b++) delta = delta | (int'(d[11 + i*dw + b]) << b);
      if (delta >= (1 << (dw - 1))) delta = delta - (1 << dw);
      flit[i*8 +: 8] = 8'((base + delta) & 255);
    end
    return {1'b0, flit};
  endfunction

  // Send one flit, check latency, hold the result under backpressure, then release it.
  task automatic run_flit(input string tag, input logic is_comp, input logic [127:0] d,
                          input logic [128:0] exp, input int hold);
    int lat;
    int exp_lat;
    exp_lat = (is_comp && !exp[128]) ? 5 : 1;
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, {127'h0, in_ready}, 128'h1);
    in_valid   = 1'b1;
    in_is_comp = is_comp;
    in_data    = d;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_is_comp = 1'($urandom);
    in_data    = rand128();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    for (int k = 0; k <= hold; k++) begin
      if (k > 0) @(negedge clk);
      chk({tag, "_out_valid"}, {127'h0, out_valid}, 128'h1);
      chk({tag, "_out_data"}, out_data, exp[127:0]);
      chk({tag, "_out_err"}, {127'h0, out_err}, {127'h0, exp[128]});
      chk({tag, "_in_ready_done"}, {127'h0, in_ready}, 128'h0);
      chk({tag, "_busy_done"}, {127'h0, busy}, 128'h1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_valid_drop"}, {127'h0, out_valid}, 128'h0);
    chk({tag, "_err_drop"}, {127'h0, out_err}, 128'h0);
    chk({tag, "_in_ready_back"}, {127'h0, in_ready}, 128'h1);
    chk({tag, "_busy_idle"}, {127'h0, busy}, 128'h0);
  endtask

  initial begin
    logic [127:0] d;
    logic         ic;
    tests      = 0;
    fails      = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_is_comp = 1'b0;
    in_data    = 128'h0;
    out_ready  = 1'b0;

    // Reset state.
    #2;
    chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_out_err", {127'h0, out_err}, 128'h0);
    chk("rst_busy", {127'h0, busy}, 128'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {127'h0, in_ready}, 128'h1);

    // Uniform flit: base 0x55, dw_code 0, all deltas 0.
    d = 128'h55;
    run_flit("uniform", 1'b1, d, {1'b0, 128'h55555555_55555555_55555555_55555555}, 0);

    // Alternating deltas: base 0x10, DW=4, +3 on even chunks, -2 on odd chunks.
    d = 128'h10 | (128'h3 << 8);
    for (int i = 0; i < 16; i++) d[11 + 4*i +: 4] = (i % 2 == 0) ? 4'h3 : 4'hE;
    run_flit("alternating", 1'b1, d, {1'b0, 128'h0E130E13_0E130E13_0E130E13_0E130E13}, 1);

    // Wrap-around: base 0xFE, DW=3, delta0=+3, delta1=-4.
    d = 128'hFE | (128'h2 << 8);
    d[11 +: 3] = 3'b011;
    d[14 +: 3] = 3'b100;
    run_flit("wrap", 1'b1, d, {1'b0, 128'hFEFEFEFE_FEFEFEFE_FEFEFEFE_FEFEFA01}, 0);

    // Raw flit bypass, held 5 cycles under backpressure.
    d = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    run_flit("raw", 1'b0, d, {1'b0, d}, 5);

    // Illegal delta-width code 7.
    d = rand128();
    d[10:8] = 3'd7;
    run_flit("illegal", 1'b1, d, {1'b1, 128'h0}, 2);

    // Reset in the middle of DECODE.
    d = rand128();
    d[7:0]  = 8'hA5;
    d[10:8] = 3'd1;
    @(negedge clk);
    in_valid   = 1'b1;
    in_is_comp = 1'b1;
    in_data    = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {127'h0, out_valid}, 128'h0);
    chk("midrst_busy", {127'h0, busy}, 128'h0);
    chk("midrst_out_data", out_data, 128'h0);
    chk("midrst_out_err", {127'h0, out_err}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    d = rand128();
    d[10:8] = 3'($urandom_range(0, 6));
    run_flit("post_rst", 1'b1, d, model(1'b1, d), 0);

    // Randomized flits against the reference model.
    for (int n = 0; n < 40; n++) begin
      d  = rand128();
      ic = ($urandom_range(0, 3) != 0);
      run_flit("random", ic, d, model(ic, d), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
